// File: rtl/cmd_types_pkg.sv
// Shared command-stream definitions: opcodes, payload layouts and opcode length table.
// Used by both the command decoder and cmd_stream_arbiter so their framing cannot diverge.
package cmd_types_pkg;

    typedef logic [7:0] byte_t;

    // Payload layouts as they appear on the byte stream, first field first.
    typedef struct packed {
        logic [7:0]  model_id;
        logic [7:0]  tri_idx;
        logic [15:0] color;
    } cmd_triangle_t;

    typedef struct packed {
        logic [7:0] instance_id;
        logic [7:0] model_id;
        logic [7:0] flags;
    } cmd_scene_t;

    localparam byte_t CMD_BEGIN_MODEL_UPLOAD = 8'hA0;
    localparam byte_t CMD_UPLOAD_TRIANGLE    = 8'hA1;
    localparam byte_t CMD_ADD_MODEL_INSTANCE = 8'hB0;

    localparam int CMD_TRI_LEN   = 1 + $bits(cmd_triangle_t) / 8;
    localparam int CMD_SCENE_LEN = 1 + $bits(cmd_scene_t) / 8;

    // Total command length in bytes, opcode included; unknown opcodes are single-byte.
    function automatic byte_t cmd_length_bytes(input byte_t opcode);
        byte_t len;
        case (opcode)
            CMD_BEGIN_MODEL_UPLOAD: len = 8'd2;
            CMD_UPLOAD_TRIANGLE:    len = 8'(CMD_TRI_LEN);
            CMD_ADD_MODEL_INSTANCE: len = 8'(CMD_SCENE_LEN);
            default:                len = 8'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_idx, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after last_idx wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int off = N; off >= 1; off--) begin
            cand = IW'((int'(last_idx) + off) % N);
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Command-granular round-robin arbiter feeding the command decoder's byte stream.
// Optional CMD_ARB_TIMEOUT_EN: a stalled command is padded out with 0x00 bytes.
module cmd_stream_arbiter
    import cmd_types_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int TRI_CMD_LEN    = 1 + $bits(cmd_triangle_t) / 8,
    parameter int SCENE_CMD_LEN  = 1 + $bits(cmd_scene_t) / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*8-1:0]       src_data,
    output logic                       cmd_out_valid,
    input  logic                       cmd_out_ready,
    output logic [7:0]                 cmd_out_data,
    output logic                       grant_valid,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       timeout_pulse
);

    localparam int IW = $clog2(NUM_SRC);

    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
        $error("cmd_stream_arbiter: NUM_SRC must be 2..8");
    end
    if (TRI_CMD_LEN < 1 || TRI_CMD_LEN > 255 || SCENE_CMD_LEN < 1 || SCENE_CMD_LEN > 255) begin : g_bad_len
        $error("cmd_stream_arbiter: command lengths must fit the 8-bit byte counter");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cmd_stream_arbiter: TIMEOUT_CYCLES must fit the 16-bit stall counter");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPCODE  = 2'd1,
        ST_PAYLOAD = 2'd2
`ifdef CMD_ARB_TIMEOUT_EN
        , ST_PAD   = 2'd3
`endif
    } arb_state_e;

    // The arbiter's own lengths win for A1/B0 so a parameter override stays self-consistent.
    function automatic byte_t op_len(input byte_t op);
        byte_t len;
        case (op)
            CMD_UPLOAD_TRIANGLE:    len = 8'(TRI_CMD_LEN);
            CMD_ADD_MODEL_INSTANCE: len = 8'(SCENE_CMD_LEN);
            default:                len = cmd_length_bytes(op);
        endcase
        return len;
    endfunction

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;
    logic          grant_valid_q, grant_valid_d;
    logic [IW-1:0] last_idx_q, last_idx_d;
    byte_t         bytes_left_q, bytes_left_d;

    logic [IW-1:0] rr_idx;
    logic          rr_any;
    logic          sel_valid;
    byte_t         sel_data;
    byte_t         len_c;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req      (src_valid),
        .last_idx (last_idx_q),
        .gnt_idx  (rr_idx),
        .gnt_any  (rr_any)
    );

    assign sel_valid = src_valid[grant_idx_q];
    assign sel_data  = src_data[{grant_idx_q, 3'b000} +: 8];
    assign len_c     = op_len(sel_data);

`ifdef CMD_ARB_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        pulse_c;
    assign timeout_pulse = pulse_c;
`else
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        last_idx_d    = last_idx_q;
        bytes_left_d  = bytes_left_q;
        src_ready     = '0;
        cmd_out_valid = 1'b0;
        cmd_out_data  = 8'h00;
`ifdef CMD_ARB_TIMEOUT_EN
        stall_d       = stall_q;
        pulse_c       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_idx_d   = rr_idx;
                    grant_valid_d = 1'b1;
                    state_d       = ST_OPCODE;
                end
            end
            ST_OPCODE: begin
                cmd_out_valid          = sel_valid;
                cmd_out_data           = sel_data;
                src_ready[grant_idx_q] = cmd_out_ready;
                if (sel_valid && cmd_out_ready) begin
`ifdef CMD_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (len_c <= 8'd1) begin
                        bytes_left_d  = 8'd0;
                        grant_valid_d = 1'b0;
                        last_idx_d    = grant_idx_q;
                        state_d       = ST_IDLE;
                    end else begin
                        bytes_left_d = len_c - 8'd1;
                        state_d      = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                cmd_out_valid          = sel_valid;
                cmd_out_data           = sel_data;
                src_ready[grant_idx_q] = cmd_out_ready;
                if (sel_valid && cmd_out_ready) begin
`ifdef CMD_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                    bytes_left_d = bytes_left_q - 8'd1;
                    if (bytes_left_q == 8'd1) begin
                        grant_valid_d = 1'b0;
                        last_idx_d    = grant_idx_q;
                        state_d       = ST_IDLE;
                    end
                end
`ifdef CMD_ARB_TIMEOUT_EN
                else if (!sel_valid) begin
                    if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        stall_d = '0;
                        state_d = ST_PAD;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end
`endif
            end
`ifdef CMD_ARB_TIMEOUT_EN
            // Zero bytes complete the abandoned command so the decoder stays framed.
            ST_PAD: begin
                cmd_out_valid = 1'b1;
                cmd_out_data  = 8'h00;
                if (cmd_out_ready) begin
                    bytes_left_d = bytes_left_q - 8'd1;
                    if (bytes_left_q == 8'd1) begin
                        pulse_c       = 1'b1;
                        grant_valid_d = 1'b0;
                        last_idx_d    = grant_idx_q;
                        state_d       = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            last_idx_q    <= IW'(NUM_SRC - 1);
            bytes_left_q  <= 8'd0;
`ifdef CMD_ARB_TIMEOUT_EN
            stall_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            last_idx_q    <= last_idx_d;
            bytes_left_q  <= bytes_left_d;
`ifdef CMD_ARB_TIMEOUT_EN
            stall_q       <= stall_d;
`endif
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Directed bench for cmd_stream_arbiter (NUM_SRC=2, TRI=5, SCENE=4, TIMEOUT=8).
// Handshake: a byte moves on a rising edge where valid and ready are both high.
module tb_cmd_stream_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  src_valid = '0;
  logic [1:0]  src_ready;
  logic [15:0] src_data = '0;
  logic        cmd_out_valid;
  logic        cmd_out_ready = 1'b0;
  logic [7:0]  cmd_out_data;
  logic        grant_valid;
  logic [0:0]  grant_idx;
  logic        timeout_pulse;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] s0_bytes [5] = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] s1_bytes [4] = '{8'hB0, 8'h01, 8'h02, 8'h03};
  logic [7:0] bp_data  [7] = '{8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
  logic       bp_rdy   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  cmd_stream_arbiter #(
    .NUM_SRC        (2),
    .TRI_CMD_LEN    (5),
    .SCENE_CMD_LEN  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .cmd_out_valid (cmd_out_valid),
    .cmd_out_ready (cmd_out_ready),
    .cmd_out_data  (cmd_out_data),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .timeout_pulse (timeout_pulse)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1, input logic r);
    @(negedge clk);
    src_valid     = v;
    src_data      = {d1, d0};
    cmd_out_ready = r;
    #1;
  endtask

  task automatic out(input string tag, input logic ov, input logic [7:0] od, input logic [1:0] sr,
                     input logic tp = 1'b0);
    chk({tag, "/out_valid"}, 8'(cmd_out_valid), 8'(ov));
    if (ov) chk({tag, "/out_data"}, cmd_out_data, od);
    chk({tag, "/src_ready"}, 8'(src_ready), 8'(sr));
    chk({tag, "/timeout_pulse"}, 8'(timeout_pulse), 8'(tp));
  endtask

  task automatic gnt(input string tag, input logic gv, input logic gi);
    chk({tag, "/grant_valid"}, 8'(grant_valid), 8'(gv));
    chk({tag, "/grant_idx"}, 8'(grant_idx), 8'(gi));
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    out("reset", 1'b0, 8'h00, 2'b00);
    chk("reset/out_data", cmd_out_data, 8'h00);
    gnt("reset", 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // A0 07 from src0: one bubble, two bytes back to back, grant drops after 07
    drive(2'b01, 8'hA0, 8'h00, 1'b1); out("t1.bubble", 1'b0, 8'h00, 2'b00); gnt("t1.bubble", 1'b0, 1'b0);
    drive(2'b01, 8'hA0, 8'h00, 1'b1); out("t1.op", 1'b1, 8'hA0, 2'b01);     gnt("t1.op", 1'b1, 1'b0);
    drive(2'b01, 8'h07, 8'h00, 1'b1); out("t1.pay", 1'b1, 8'h07, 2'b01);    gnt("t1.pay", 1'b1, 1'b0);
    drive(2'b00, 8'h00, 8'h00, 1'b1); out("t1.end", 1'b0, 8'h00, 2'b00);    gnt("t1.end", 1'b0, 1'b0);

    // src0 streams 0x55 singles, src1 streams A0 01: grants alternate, src1 first (last_idx=0)
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 8'h55, 8'hA0, 1'b1); out("alt.bub1", 1'b0, 8'h00, 2'b00);
      drive(2'b11, 8'h55, 8'hA0, 1'b1); out("alt.s1op", 1'b1, 8'hA0, 2'b10); gnt("alt.s1op", 1'b1, 1'b1);
      drive(2'b11, 8'h55, 8'h01, 1'b1); out("alt.s1pay", 1'b1, 8'h01, 2'b10);
      drive(2'b11, 8'h55, 8'hA0, 1'b1); out("alt.bub0", 1'b0, 8'h00, 2'b00); gnt("alt.bub0", 1'b0, 1'b1);
      drive(2'b11, 8'h55, 8'hA0, 1'b1); out("alt.s0", 1'b1, 8'h55, 2'b01);   gnt("alt.s0", 1'b1, 1'b0);
    end
    drive(2'b10, 8'h55, 8'hA0, 1'b1); out("alt.bub2", 1'b0, 8'h00, 2'b00);
    drive(2'b10, 8'h55, 8'hA0, 1'b1); out("alt.s1op2", 1'b1, 8'hA0, 2'b10); gnt("alt.s1op2", 1'b1, 1'b1);
    drive(2'b10, 8'h55, 8'h01, 1'b1); out("alt.s1pay2", 1'b1, 8'h01, 2'b10);

    // both valid with last_idx=1: src0 A1 (5 bytes) whole, then src1 B0 (4 bytes)
    drive(2'b11, 8'hA1, 8'hB0, 1'b1); out("t2.bubble", 1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, s0_bytes[i], 8'hB0, 1'b1);
      out($sformatf("t2.s0[%0d]", i), 1'b1, s0_bytes[i], 2'b01);
      gnt($sformatf("t2.s0[%0d]", i), 1'b1, 1'b0);
    end
    drive(2'b10, 8'h00, 8'hB0, 1'b1); out("t2.bubble2", 1'b0, 8'h00, 2'b00); gnt("t2.bubble2", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 8'h00, s1_bytes[i], 1'b1);
      out($sformatf("t2.s1[%0d]", i), 1'b1, s1_bytes[i], 2'b10);
      gnt($sformatf("t2.s1[%0d]", i), 1'b1, 1'b1);
    end
    drive(2'b00, 8'h00, 8'h00, 1'b1); gnt("t2.end", 1'b0, 1'b1);

    // backpressure toggling during A1 payload: held bytes repeat on the wire, counted once
    drive(2'b01, 8'hA1, 8'h00, 1'b1); out("t4.bubble", 1'b0, 8'h00, 2'b00);
    drive(2'b01, 8'hA1, 8'h00, 1'b1); out("t4.op", 1'b1, 8'hA1, 2'b01);
    for (int i = 0; i < 7; i++) begin
      drive(2'b01, bp_data[i], 8'h00, bp_rdy[i]);
      out($sformatf("t4.pay[%0d]", i), 1'b1, bp_data[i], {1'b0, bp_rdy[i]});
      gnt($sformatf("t4.pay[%0d]", i), 1'b1, 1'b0);
    end
    drive(2'b00, 8'h00, 8'h00, 1'b1); out("t4.end", 1'b0, 8'h00, 2'b00); gnt("t4.end", 1'b0, 1'b0);

    // reset after two bytes of A1, then src1 B0 granted cleanly
    drive(2'b01, 8'hA1, 8'h00, 1'b1);
    drive(2'b01, 8'hA1, 8'h00, 1'b1); out("t5.op", 1'b1, 8'hA1, 2'b01);
    drive(2'b01, 8'h11, 8'h00, 1'b1); out("t5.pay", 1'b1, 8'h11, 2'b01);
    drive(2'b01, 8'h22, 8'h00, 1'b1);
    rstn = 1'b0;
    #1;
    out("t5.in_reset", 1'b0, 8'h00, 2'b00); gnt("t5.in_reset", 1'b0, 1'b0);
    drive(2'b10, 8'h00, 8'hB0, 1'b1);
    rstn = 1'b1;
    #1;
    out("t5.bubble", 1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 8'h00, s1_bytes[i], 1'b1);
      out($sformatf("t5.s1[%0d]", i), 1'b1, s1_bytes[i], 2'b10);
      gnt($sformatf("t5.s1[%0d]", i), 1'b1, 1'b1);
    end
    drive(2'b00, 8'h00, 8'h00, 1'b1); gnt("t5.end", 1'b0, 1'b1);

`ifdef CMD_ARB_TIMEOUT_EN
    // A1 11 then src0 stops: 8 stall cycles, three 0x00 pad bytes, pulse on the last
    drive(2'b01, 8'hA1, 8'h00, 1'b1);
    drive(2'b01, 8'hA1, 8'h00, 1'b1); out("to.op", 1'b1, 8'hA1, 2'b01);
    drive(2'b01, 8'h11, 8'h00, 1'b1); out("to.pay", 1'b1, 8'h11, 2'b01);
    for (int i = 0; i < 8; i++) begin
      drive(2'b00, 8'h00, 8'h00, 1'b1);
      out($sformatf("to.stall[%0d]", i), 1'b0, 8'h00, 2'b01);
    end
    drive(2'b00, 8'h00, 8'h00, 1'b1); out("to.pad0", 1'b1, 8'h00, 2'b00, 1'b0);
    drive(2'b00, 8'h00, 8'h00, 1'b1); out("to.pad1", 1'b1, 8'h00, 2'b00, 1'b0);
    drive(2'b00, 8'h00, 8'h00, 1'b1); out("to.pad2", 1'b1, 8'h00, 2'b00, 1'b1);
    drive(2'b10, 8'h00, 8'hB0, 1'b1); out("to.bubble", 1'b0, 8'h00, 2'b00); gnt("to.bubble", 1'b0, 1'b0);
    drive(2'b10, 8'h00, 8'hB0, 1'b1); out("to.next", 1'b1, 8'hB0, 2'b10); gnt("to.next", 1'b1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_stream_arbiter.md
Name: cmd_stream_arbiter

Overview:
- Shares the single command byte stream into the command decoder between NUM_SRC byte-stream requesters (e.g. SPI host link, debug UART).
- Grants one source per whole command, using the command opcode to know the command length. The grant is never switched mid-command, so the decoder's byte parallelizers stay aligned.
- Selection among sources is round-robin.
- Sits directly upstream of the command decoder's cmd_in interface.

Parameters:
- NUM_SRC, 2, number of requesting byte streams (2..8).
- TRI_CMD_LEN, 1+$bits(cmd_triangle_t)/8, total bytes of an 0xA1 command, including the opcode.
- SCENE_CMD_LEN, 1+$bits(cmd_scene_t)/8, total bytes of an 0xB0 command, including the opcode.
- TIMEOUT_CYCLES, 1024, mid-command stall limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRC  per-source byte valid
- src_ready  out  NUM_SRC  per-source byte ready
- src_data  in  NUM_SRC*8  per-source byte; source i occupies bits [8i+7:8i]
- cmd_out_valid  out  1  byte valid to the command decoder
- cmd_out_ready  in  1  command decoder ready
- cmd_out_data  out  8  byte to the command decoder
- grant_valid  out  1  a source currently holds the stream
- grant_idx  out  $clog2(NUM_SRC)  index of the granted source
- timeout_pulse  out  1  one-cycle pulse when a command is force-completed; tied 0 without the optional feature

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rstn).
- Reset values:
  - state=IDLE, grant_valid=0, grant_idx=0, src_ready=0, cmd_out_valid=0, cmd_out_data=0, timeout_pulse=0.
  - Round-robin pointer last_idx=NUM_SRC-1, so source 0 has first priority.
  - bytes_left=0.
- Reset asserted mid-command returns the block to IDLE immediately. The partial command is discarded; the downstream decoder is reset by the same rstn.
- IDLE:
  - src_ready=0, cmd_out_valid=0.
  - If any src_valid is high, register the winner: the first valid index scanning last_idx+1, last_idx+2, ... modulo NUM_SRC.
  - Set grant_idx=winner, grant_valid=1, go to OPCODE.
  - Exactly one bubble cycle per command.
- OPCODE:
  - cmd_out_valid=src_valid[grant_idx], cmd_out_data=src_data[grant_idx].
  - src_ready[grant_idx]=cmd_out_ready; all other src_ready are 0. Purely combinational pass-through, zero added latency.
  - On transfer, set bytes_left = len(opcode)-1, where len is: 0xA0 -> 2, 0xA1 -> TRI_CMD_LEN, 0xB0 -> SCENE_CMD_LEN, anything else -> 1.
  - If bytes_left would be 0, go to IDLE and set last_idx=grant_idx. Otherwise go to PAYLOAD.
- PAYLOAD:
  - Same pass-through as OPCODE.
  - Each transfer decrements bytes_left.
  - The transfer with bytes_left==1 ends the command: next state IDLE, grant_valid=0, last_idx=grant_idx.
- Source stall: if the granted src_valid drops mid-command, the block waits indefinitely (without the optional feature). Other sources stay blocked.
- Downstream backpressure: cmd_out_ready=0 holds everything; no byte is lost or duplicated.
- Simultaneous requests: the round-robin pointer guarantees each valid source is granted at most once before another waiting source is served.
- bytes_left is 8 bits wide. TRI_CMD_LEN and SCENE_CMD_LEN must each be <=255; an elaboration check enforces this.

Optional Feature:
- Macro: CMD_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter runs in PAYLOAD. It counts cycles with src_valid[grant_idx]==0 and clears on any source transfer.
  - When the counter reaches TIMEOUT_CYCLES, the state becomes PAD: cmd_out_valid=1, cmd_out_data=0x00, and src_ready for all sources is 0.
  - PAD continues until bytes_left reaches 0, then goes to IDLE, pulsing timeout_pulse in the cycle of the final pad transfer.
  - This keeps the decoder aligned.
- Not defined: no counter and no PAD state; timeout_pulse is tied 0.

Decomposition:
- Add to cmd_types_pkg:
  - opcode constants CMD_BEGIN_MODEL_UPLOAD=0xA0, CMD_UPLOAD_TRIANGLE=0xA1, CMD_ADD_MODEL_INSTANCE=0xB0;
  - function cmd_length_bytes(byte_t) returning byte_t.
- The command decoder is switched to use these shared definitions, so the two blocks cannot diverge.
- Arbiter state enum stays local.
- Sub-module rr_arbiter (parameter N): inputs req[N], last_idx; outputs gnt_idx, gnt_any. Purely combinational, reusable.

Test Plan (TRI_CMD_LEN=5, SCENE_CMD_LEN=4, NUM_SRC=2, TIMEOUT_CYCLES=8):
- Src0 sends A0 07 with out_ready=1 -> after 1 bubble cycle, out sees A0 then 07 on consecutive cycles; grant_valid falls after 07; last_idx=0.
- Both sources valid; src0 sends A1+4 bytes, src1 sends B0+3 bytes -> out gets 5 src0 bytes uninterrupted, then 4 src1 bytes; src1 ready=0 throughout src0's command.
- Src0 continuously sends unknown opcode 0x55, src1 continuously sends A0 01 -> grants alternate 0,1,0,1; each 0x55 is a 1-byte command.
- cmd_out_ready toggles 1,0,1,0 during A1 payload -> 5 bytes delivered in order with no duplicates; src ready mirrors cmd_out_ready.
- rstn asserted after 2 bytes of A1 -> grant_valid, cmd_out_valid and src_ready are 0 immediately; after release, src1's B0 command is granted cleanly.
- (CMD_ARB_TIMEOUT_EN) src0 sends A1 11 then stops -> after 8 stall cycles, out emits 00 00 00; timeout_pulse=1 on the last pad byte; next request is granted normally.
